// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_pkg;

  // Memory-access sequencing states.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // EX operand mux selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // True when a later-stage writer produces the register a reader needs.
  // x0 is hard-wired to zero and must never be forwarded or waited on.
  function automatic logic reg_hit(input logic       wr,
                                   input logic [4:0] rd,
                                   input logic [4:0] rs);
    return wr && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding select generator.
// Latency: purely combinational, zero cycles.
// Backpressure: none; selects follow the stage register contents every cycle.
//
// Ports:
//   ex_rs1_addr, ex_rs2_addr   sources of the instruction in EX
//   mem_rd_addr, mem_rd_wr     destination/write flag of the MEM instruction
//   wb_rd_addr,  wb_rd_wr      destination/write flag of the WB instruction
//   fwd_a_sel,   fwd_b_sel     operand mux selects (FWD_RF / FWD_MEM / FWD_WB)
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] ex_rs1_addr,
  input  logic [4:0] ex_rs2_addr,
  input  logic [4:0] mem_rd_addr,
  input  logic       mem_rd_wr,
  input  logic [4:0] wb_rd_addr,
  input  logic       wb_rd_wr,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel
);

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    fwd_a_sel = FWD_RF;
    if (reg_hit(mem_rd_wr, mem_rd_addr, ex_rs1_addr)) begin
      fwd_a_sel = FWD_MEM;
    end else if (reg_hit(wb_rd_wr, wb_rd_addr, ex_rs1_addr)) begin
      fwd_a_sel = FWD_WB;
    end

    fwd_b_sel = FWD_RF;
    if (reg_hit(mem_rd_wr, mem_rd_addr, ex_rs2_addr)) begin
      fwd_b_sel = FWD_MEM;
    end else if (reg_hit(wb_rd_wr, wb_rd_addr, ex_rs2_addr)) begin
      fwd_b_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the 5-stage core: stage enables, flushes, forwarding, dmem wait.
// Latency: controls are combinational on the current cycle; status/counters update at the edge.
// Backpressure: a pending dmem access freezes every stage until ack or MEM_TIMEOUT abort.
//
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   id_*/ex_*/mem_*/wb_*        register addresses and flags from each stage
//   mem_req_i, mem_ack_i        dmem access held in MEM / completion strobe
//   *_en_o, *_flush_o, mem_wb_bubble_o   pipeline register controls
//   fwd_a_sel_o, fwd_b_sel_o    EX operand forwarding selects
//   dmem_req_o, bus_err_o       dmem request strobe, sticky timeout flag
//   stall_cnt_o, flush_cnt_o    performance counters
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_rs1_addr_i,
  input  logic [4:0]       ex_rs2_addr_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_rd_wr_i,
  input  logic             ex_is_load_i,
  input  logic             ex_pc_sel_i,
  input  logic [4:0]       mem_rd_addr_i,
  input  logic             mem_rd_wr_i,
  input  logic [4:0]       wb_rd_addr_i,
  input  logic             wb_rd_wr_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             mem_wb_bubble_o,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic             dmem_req_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // Largest wait count held is MEM_TIMEOUT-1, which fits in clog2(MEM_TIMEOUT) bits.
  localparam int                WCNT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               bus_err_q;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;

  logic req_live;
  logic freeze;
  logic abort;
  logic load_use;
  logic stall_lu;
  logic redirect;

  fwd_unit u_fwd (
    .ex_rs1_addr (ex_rs1_addr_i),
    .ex_rs2_addr (ex_rs2_addr_i),
    .mem_rd_addr (mem_rd_addr_i),
    .mem_rd_wr   (mem_rd_wr_i),
    .wb_rd_addr  (wb_rd_addr_i),
    .wb_rd_wr    (wb_rd_wr_i),
    .fwd_a_sel   (fwd_a_sel_o),
    .fwd_b_sel   (fwd_b_sel_o)
  );

  // Masking with reset keeps the request strobe low (and the pipe released)
  // while reset is asserted, even if MEM still presents an access.
  assign req_live = mem_req_i & rst_ni;

  assign load_use = ex_is_load_i &&
                    ((id_uses_rs1_i && reg_hit(ex_rd_wr_i, ex_rd_addr_i, id_rs1_addr_i)) ||
                     (id_uses_rs2_i && reg_hit(ex_rd_wr_i, ex_rd_addr_i, id_rs2_addr_i)));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    abort      = 1'b0;
    dmem_req_o = 1'b0;
    unique case (state_q)
      RUN: begin
        dmem_req_o = req_live;
        if (req_live && !mem_ack_i) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        dmem_req_o = 1'b1;
        if (mem_ack_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Give up on the access: release the pipe and retire a NOP instead.
          abort      = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Hazards are only acted on in a cycle where the pipe actually advances.
  // A taken redirect squashes the dependent instruction, so it cancels the stall.
  assign redirect = !freeze && ex_pc_sel_i;
  assign stall_lu = !freeze && load_use && !ex_pc_sel_i;

  assign pc_en_o         = !freeze && !stall_lu;
  assign if_id_en_o      = !freeze && !stall_lu;
  assign id_ex_en_o      = !freeze;
  assign ex_mem_en_o     = !freeze;
  assign mem_wb_en_o     = !freeze;
  assign if_id_flush_o   = redirect;
  assign id_ex_flush_o   = redirect || stall_lu;
  assign mem_wb_bubble_o = abort;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (abort) begin
        bus_err_q <= 1'b1;
      end
      if (!pc_en_o) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (redirect) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus_err_o   = bus_err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by random traffic
// compared each cycle against a behavioural model based on request age.
module tb_pipe_hazard_ctrl;

  localparam int MT = 4;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_ni;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i;
  logic       id_uses_rs1_i, id_uses_rs2_i;
  logic [4:0] ex_rs1_addr_i, ex_rs2_addr_i, ex_rd_addr_i;
  logic       ex_rd_wr_i, ex_is_load_i, ex_pc_sel_i;
  logic [4:0] mem_rd_addr_i, wb_rd_addr_i;
  logic       mem_rd_wr_i, wb_rd_wr_i, mem_req_i, mem_ack_i;
  logic       pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o;
  logic       if_id_flush_o, id_ex_flush_o, mem_wb_bubble_o;
  logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
  logic       dmem_req_o, bus_err_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  int errors = 0;
  int checks = 0;

  // Model state: age = cycles the current dmem access has already been outstanding.
  int          age;
  logic        m_err;
  logic [31:0] m_stall, m_flush;

  // Model expectations for the current cycle.
  logic       e_pc_en, e_if_id_en, e_other_en, e_if_flush, e_id_flush, e_bubble, e_dreq;
  logic [1:0] e_fa, e_fb;
  logic       e_freeze, e_abort, e_redir;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .ex_rs1_addr_i(ex_rs1_addr_i), .ex_rs2_addr_i(ex_rs2_addr_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_wr_i(ex_rd_wr_i),
    .ex_is_load_i(ex_is_load_i), .ex_pc_sel_i(ex_pc_sel_i),
    .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_wr_i(mem_rd_wr_i),
    .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_wr_i(wb_rd_wr_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_en_o(pc_en_o), .if_id_en_o(if_id_en_o), .id_ex_en_o(id_ex_en_o),
    .ex_mem_en_o(ex_mem_en_o), .mem_wb_en_o(mem_wb_en_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
    .mem_wb_bubble_o(mem_wb_bubble_o),
    .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o),
    .dmem_req_o(dmem_req_o), .bus_err_o(bus_err_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (mem_rd_wr_i && mem_rd_addr_i != 0 && mem_rd_addr_i == rs) return 2'b01;
    if (wb_rd_wr_i && wb_rd_addr_i != 0 && wb_rd_addr_i == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_eval();
    logic active, lu, stall;
    active   = rst_ni && (age > 0 || mem_req_i);
    e_dreq   = active;
    e_freeze = active && !mem_ack_i && (age + 1 < MT);
    e_abort  = active && !mem_ack_i && (age + 1 >= MT);
    lu = ex_is_load_i && ex_rd_wr_i && ex_rd_addr_i != 0 &&
         ((id_uses_rs1_i && id_rs1_addr_i == ex_rd_addr_i) ||
          (id_uses_rs2_i && id_rs2_addr_i == ex_rd_addr_i));
    e_fa = ref_fwd(ex_rs1_addr_i);
    e_fb = ref_fwd(ex_rs2_addr_i);
    if (e_freeze) begin
      e_pc_en = 0; e_if_id_en = 0; e_other_en = 0;
      e_if_flush = 0; e_id_flush = 0; e_bubble = 0; e_redir = 0;
    end else begin
      stall      = lu && !ex_pc_sel_i;
      e_redir    = ex_pc_sel_i;
      e_pc_en    = !stall;
      e_if_id_en = !stall;
      e_other_en = 1;
      e_if_flush = ex_pc_sel_i;
      e_id_flush = ex_pc_sel_i || lu;
      e_bubble   = e_abort;
    end
  endtask

  task automatic check_all();
    model_eval();
    chk("pc_en", pc_en_o, e_pc_en);
    chk("if_id_en", if_id_en_o, e_if_id_en);
    chk("id_ex_en", id_ex_en_o, e_other_en);
    chk("ex_mem_en", ex_mem_en_o, e_other_en);
    chk("mem_wb_en", mem_wb_en_o, e_other_en);
    chk("if_id_flush", if_id_flush_o, e_if_flush);
    chk("id_ex_flush", id_ex_flush_o, e_id_flush);
    chk("mem_wb_bubble", mem_wb_bubble_o, e_bubble);
    chk("fwd_a", fwd_a_sel_o, e_fa);
    chk("fwd_b", fwd_b_sel_o, e_fb);
    chk("dmem_req", dmem_req_o, e_dreq);
    chk("bus_err", bus_err_o, m_err);
    chk("stall_cnt", stall_cnt_o, m_stall);
    chk("flush_cnt", flush_cnt_o, m_flush);
  endtask

  // Check the current cycle, then advance one clock and the model with it.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    if (!e_pc_en) m_stall = m_stall + 1;
    if (e_redir) m_flush = m_flush + 1;
    if (e_abort) m_err = 1'b1;
    age = e_freeze ? age + 1 : 0;
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_uses_rs1_i = 0; id_uses_rs2_i = 0;
    ex_rs1_addr_i = 0; ex_rs2_addr_i = 0; ex_rd_addr_i = 0;
    ex_rd_wr_i = 0; ex_is_load_i = 0; ex_pc_sel_i = 0;
    mem_rd_addr_i = 0; mem_rd_wr_i = 0; wb_rd_addr_i = 0; wb_rd_wr_i = 0;
    mem_req_i = 0; mem_ack_i = 0;
  endtask

  // Assert reset (inputs left as they are), check the held state, release with idle inputs.
  task automatic do_reset();
    rst_ni = 1'b0;
    age = 0; m_err = 0; m_stall = 0; m_flush = 0;
    #1;
    check_all();
    chk("rst_dmem_req", dmem_req_o, 1'b0);
    chk("rst_pc_en", pc_en_o, 1'b1);
    chk("rst_mem_wb_en", mem_wb_en_o, 1'b1);
    chk("rst_bus_err", bus_err_o, 1'b0);
    chk("rst_stall_cnt", stall_cnt_o, 32'd0);
    chk("rst_flush_cnt", flush_cnt_o, 32'd0);
    @(posedge clk);
    #1;
    clear_inputs();
    rst_ni = 1'b1;
  endtask

  task automatic set_load_use();
    ex_is_load_i = 1; ex_rd_wr_i = 1; ex_rd_addr_i = 5;
    id_rs1_addr_i = 5; id_uses_rs1_i = 1;
  endtask

  initial begin
    int en_low, req_hi, bub_at;
    logic sticky_ok;
    clear_inputs();
    rst_ni = 1'b0;
    age = 0; m_err = 0; m_stall = 0; m_flush = 0;
    do_reset();

    // Forwarding priority and x0 exclusion.
    ex_rs1_addr_i = 3; ex_rs2_addr_i = 3;
    mem_rd_addr_i = 3; wb_rd_addr_i = 3; mem_rd_wr_i = 1; wb_rd_wr_i = 1;
    #1 chk("fwd_a_mem_prio", fwd_a_sel_o, 2'b01);
    cycle();
    mem_rd_wr_i = 0;
    #1 chk("fwd_a_wb", fwd_a_sel_o, 2'b10);
    chk("fwd_b_wb", fwd_b_sel_o, 2'b10);
    cycle();
    ex_rs2_addr_i = 0; wb_rd_addr_i = 0;
    #1 chk("fwd_b_x0", fwd_b_sel_o, 2'b00);
    cycle();

    // Load-use stall, then the same with rd = x0.
    clear_inputs(); do_reset();
    set_load_use();
    #1 chk("lu_pc_en", pc_en_o, 1'b0);
    chk("lu_if_id_en", if_id_en_o, 1'b0);
    chk("lu_id_ex_flush", id_ex_flush_o, 1'b1);
    cycle();
    clear_inputs();
    #1 chk("lu_stall_cnt", stall_cnt_o, 32'd1);
    cycle();
    set_load_use(); ex_rd_addr_i = 0;
    #1 chk("lu_x0_pc_en", pc_en_o, 1'b1);
    cycle();
    clear_inputs();
    #1 chk("lu_x0_stall_cnt", stall_cnt_o, 32'd1);
    cycle();

    // Redirect overrides load-use.
    clear_inputs(); do_reset();
    set_load_use(); ex_pc_sel_i = 1;
    #1 chk("rd_if_id_flush", if_id_flush_o, 1'b1);
    chk("rd_id_ex_flush", id_ex_flush_o, 1'b1);
    chk("rd_pc_en", pc_en_o, 1'b1);
    cycle();
    clear_inputs();
    #1 chk("rd_flush_cnt", flush_cnt_o, 32'd1);
    chk("rd_stall_cnt", stall_cnt_o, 32'd0);
    cycle();

    // Multi-cycle access acked on the 4th cycle.
    clear_inputs(); do_reset();
    en_low = 0; req_hi = 0;
    mem_req_i = 1;
    for (int i = 0; i < 4; i++) begin
      mem_ack_i = (i == 3);
      #1;
      if (!pc_en_o && !mem_wb_en_o) en_low++;
      if (dmem_req_o) req_hi++;
      cycle();
    end
    mem_req_i = 0; mem_ack_i = 0;
    #1 chk("mc_en_low_cycles", en_low, 3);
    chk("mc_req_cycles", req_hi, 4);
    chk("mc_stall_cnt", stall_cnt_o, 32'd3);
    chk("mc_back_to_run", dmem_req_o, 1'b0);
    cycle();

    // Timeout abort with MEM_TIMEOUT = 4.
    clear_inputs(); do_reset();
    en_low = 0; bub_at = -1;
    mem_req_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (!pc_en_o && !ex_mem_en_o) en_low++;
      if (mem_wb_bubble_o && pc_en_o && mem_wb_en_o) bub_at = i;
      cycle();
    end
    mem_req_i = 0;
    #1 chk("to_en_low_cycles", en_low, 3);
    chk("to_bubble_cycle", bub_at, 3);
    chk("to_bus_err_set", bus_err_o, 1'b1);
    sticky_ok = 1;
    for (int i = 0; i < 5; i++) begin
      #1 if (!bus_err_o) sticky_ok = 0;
      cycle();
    end
    chk("to_bus_err_sticky", sticky_ok, 1'b1);

    // Reset in the middle of a wait drops the request at once.
    clear_inputs(); do_reset();
    mem_req_i = 1;
    cycle();
    cycle();
    do_reset();

    // Random traffic against the model; ack density alternates to provoke timeouts.
    for (int n = 0; n < 400; n++) begin
      id_rs1_addr_i = 5'($urandom_range(0, 3));
      id_rs2_addr_i = 5'($urandom_range(0, 3));
      id_uses_rs1_i = 1'($urandom_range(0, 1));
      id_uses_rs2_i = 1'($urandom_range(0, 1));
      ex_rs1_addr_i = 5'($urandom_range(0, 3));
      ex_rs2_addr_i = 5'($urandom_range(0, 3));
      ex_rd_addr_i  = 5'($urandom_range(0, 3));
      ex_rd_wr_i    = 1'($urandom_range(0, 1));
      ex_is_load_i  = 1'($urandom_range(0, 1));
      ex_pc_sel_i   = ($urandom_range(0, 4) == 0);
      mem_rd_addr_i = 5'($urandom_range(0, 3));
      mem_rd_wr_i   = 1'($urandom_range(0, 1));
      wb_rd_addr_i  = 5'($urandom_range(0, 3));
      wb_rd_wr_i    = 1'($urandom_range(0, 1));
      mem_req_i     = (age > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      mem_ack_i     = ((n / 50) % 2 == 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
